// File: rtl/cam_insert_ctrl.sv
// cam_insert_ctrl: insert-with-dedup front end for a CAM.
// Searches the CAM for the offered value. A live hit returns the existing index.
// A stale hit reclaims its slot. A miss takes the lowest free slot. When no slot
// is free the insert reports full. Also tracks the occupancy bitmap and the live
// entry count, and accepts entry releases from downstream consumers.
module cam_insert_ctrl #(
  parameter  int unsigned ARRAY_WIDTH_LOG2 = 5,
  parameter  int unsigned ARRAY_SIZE_LOG2  = 5,
  localparam int unsigned DW = 2 ** ARRAY_WIDTH_LOG2,
  localparam int unsigned IW = ARRAY_SIZE_LOG2,
  localparam int unsigned N  = 2 ** ARRAY_SIZE_LOG2,
  localparam int unsigned CW = ARRAY_SIZE_LOG2 + 1
) (
  input  logic          clk,
  input  logic          reset_i,
  input  logic          insert_valid_i,
  output logic          insert_ready_o,
  input  logic [DW-1:0] insert_data_i,
  input  logic          free_i,
  input  logic [IW-1:0] free_index_i,
  output logic          result_valid_o,
  output logic [IW-1:0] result_index_o,
  output logic          result_hit_o,
  output logic          result_full_o,
  output logic [CW-1:0] count_o,
  output logic          cam_search_o,
  output logic [DW-1:0] cam_search_data_o,
  input  logic          cam_search_valid_i,
  input  logic [IW-1:0] cam_search_index_i,
  output logic          cam_write_o,
  output logic [IW-1:0] cam_write_index_o,
  output logic [DW-1:0] cam_write_data_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEARCH = 3'd1,
    S_EVAL   = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [DW-1:0] r_key;
  logic [N-1:0]  r_occ;
  logic [N-1:0]  w_occ_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;

  logic          w_accept;
  logic          w_match_live;
  logic          w_any_free;
  logic [IW-1:0] w_free_idx;
  logic          w_set_en;
  logic          w_set_new;
  logic          w_clr_eff;

  // Registered output state and the values it loads at the next edge
  logic          r_res_valid;
  logic          r_res_hit;
  logic          r_res_full;
  logic [IW-1:0] r_res_index;
  logic          r_cam_search;
  logic [DW-1:0] r_cam_search_data;
  logic          r_cam_write;
  logic [IW-1:0] r_cam_write_index;
  logic [DW-1:0] r_cam_write_data;

  logic          w_res_valid_nxt;
  logic          w_res_hit_nxt;
  logic          w_res_full_nxt;
  logic [IW-1:0] w_res_index_nxt;
  logic          w_cam_search_nxt;
  logic [DW-1:0] w_cam_search_data_nxt;
  logic          w_cam_write_nxt;
  logic [IW-1:0] w_cam_write_index_nxt;
  logic [DW-1:0] w_cam_write_data_nxt;

  assign insert_ready_o    = (r_state == S_IDLE) & ~reset_i;
  assign w_accept          = insert_valid_i & insert_ready_o;
  // A match only counts as a hit when its slot is still live in the bitmap
  assign w_match_live      = cam_search_valid_i & r_occ[cam_search_index_i];

  assign result_valid_o    = r_res_valid;
  assign result_hit_o      = r_res_hit;
  assign result_full_o     = r_res_full;
  assign result_index_o    = r_res_index;
  assign count_o           = r_count;
  assign cam_search_o      = r_cam_search;
  assign cam_search_data_o = r_cam_search_data;
  assign cam_write_o       = r_cam_write;
  assign cam_write_index_o = r_cam_write_index;
  assign cam_write_data_o  = r_cam_write_data;

  // Lowest-numbered free entry in the occupancy bitmap
  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!r_occ[i] && !w_any_free) begin
        w_any_free = 1'b1;
        w_free_idx = IW'(i);
      end
    end
  end

  // Bitmap and count update: release clears, the WRITE-state set wins on the same index
  always_comb begin
    w_set_en  = (r_state == S_WRITE);
    w_set_new = w_set_en & ~r_occ[r_cam_write_index];
    w_clr_eff = free_i & r_occ[free_index_i]
              & ~(w_set_en & (free_index_i == r_cam_write_index));
    w_occ_nxt = r_occ;
    if (free_i) begin
      w_occ_nxt[free_index_i] = 1'b0;
    end
    if (w_set_en) begin
      w_occ_nxt[r_cam_write_index] = 1'b1;
    end
    w_count_nxt = r_count + CW'(w_set_new) - CW'(w_clr_eff);
  end

  // Bitmap, count and latched key registers
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_occ   <= '0;
      r_count <= '0;
      r_key   <= '0;
    end else begin
      r_occ   <= w_occ_nxt;
      r_count <= w_count_nxt;
      if (w_accept) begin
        r_key <= insert_data_i;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SEARCH;
        end
      end
      S_SEARCH: w_state_nxt = S_EVAL;
      S_EVAL: begin
        if (w_match_live || (!cam_search_valid_i && !w_any_free)) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output logic: values the output registers hold during the next state
  always_comb begin
    w_res_valid_nxt       = 1'b0;
    w_res_hit_nxt         = 1'b0;
    w_res_full_nxt        = 1'b0;
    w_res_index_nxt       = '0;
    w_cam_search_nxt      = 1'b0;
    w_cam_search_data_nxt = '0;
    w_cam_write_nxt       = 1'b0;
    w_cam_write_index_nxt = '0;
    w_cam_write_data_nxt  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cam_search_nxt      = 1'b1;
          w_cam_search_data_nxt = insert_data_i;
        end
      end
      S_EVAL: begin
        if (w_match_live) begin
          w_res_valid_nxt = 1'b1;
          w_res_hit_nxt   = 1'b1;
          w_res_index_nxt = cam_search_index_i;
        end else if (cam_search_valid_i) begin
          // Stale match: reuse its slot so a value never lives in two slots
          w_cam_write_nxt       = 1'b1;
          w_cam_write_index_nxt = cam_search_index_i;
          w_cam_write_data_nxt  = r_key;
        end else if (w_any_free) begin
          w_cam_write_nxt       = 1'b1;
          w_cam_write_index_nxt = w_free_idx;
          w_cam_write_data_nxt  = r_key;
        end else begin
          w_res_valid_nxt = 1'b1;
          w_res_full_nxt  = 1'b1;
        end
      end
      S_WRITE: begin
        w_res_valid_nxt = 1'b1;
        w_res_index_nxt = r_cam_write_index;
      end
      default: ;
    endcase
  end

  // Output registers; reset drops any in-flight strobe or result
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_res_valid       <= 1'b0;
      r_res_hit         <= 1'b0;
      r_res_full        <= 1'b0;
      r_res_index       <= '0;
      r_cam_search      <= 1'b0;
      r_cam_search_data <= '0;
      r_cam_write       <= 1'b0;
      r_cam_write_index <= '0;
      r_cam_write_data  <= '0;
    end else begin
      r_res_valid       <= w_res_valid_nxt;
      r_res_hit         <= w_res_hit_nxt;
      r_res_full        <= w_res_full_nxt;
      r_res_index       <= w_res_index_nxt;
      r_cam_search      <= w_cam_search_nxt;
      r_cam_search_data <= w_cam_search_data_nxt;
      r_cam_write       <= w_cam_write_nxt;
      r_cam_write_index <= w_cam_write_index_nxt;
      r_cam_write_data  <= w_cam_write_data_nxt;
    end
  end

endmodule
